que_fiao_pack: RTL

Parametrised successor to the chunk-accumulating FIAO. It packs `ENQ_WIDTH`-bit chunks into an `OUT_WIDTH`-bit word through a fill buffer plus a registered output stage, so the next word can fill while the previous one waits to be dequeued. It adds selectable chunk ordering, a flush that emits a partial word with a chunk count, and no-bubble streaming. It sits between narrow chunk producers (entropy/sample sources) and wide word consumers.

---
 rtl/que_fiao_pack.sv | 103 ++++++++++
 1 files changed

// File: rtl/que_fiao_pack.sv
// Chunk-to-word packer: index-addressed fill buffer feeding a registered output
// word, with selectable chunk order and a flush that emits partial words.

module que_fiao_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         we,
  input  logic [W-1:0] din,
  output logic [W-1:0] q,
  output logic [W-1:0] d_next
);
  // d_next exposes this cycle's write so a transfer captures the last chunk
  assign d_next = we ? din : q;

  always_ff @(posedge clk) begin
    if (rst || clr) q <= '0;
    else            q <= d_next;
  end
endmodule

module que_fiao_pack #(
  parameter  int ENQ_WIDTH = 32,
  parameter  int CHUNKS    = 12,
  parameter  bit LSB_FIRST = 1'b0,
  localparam int OUT_WIDTH = ENQ_WIDTH * CHUNKS,
  localparam int CNT_W     = $clog2(CHUNKS + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ENQ_WIDTH-1:0] wdata,
  input  logic                 enque,
  output logic                 full,
  input  logic                 flush,
  output logic [OUT_WIDTH-1:0] rdata,
  output logic [CNT_W-1:0]     rcount,
  output logic                 rvalid,
  input  logic                 deque,
  output logic                 empty
);
  logic [CNT_W-1:0]                    fill_cnt;
  logic                                flush_pend;
  logic [CHUNKS-1:0][ENQ_WIDTH-1:0]    word_next;
  logic                                accept;
  logic [CNT_W-1:0]                    cnt_next;
  logic                                complete;
  logic                                out_free;
  logic                                flush_elig;
  logic                                xfer;

  assign full       = (fill_cnt == CNT_W'(CHUNKS)) || flush_pend;
  assign accept     = enque && !full;
  assign cnt_next   = fill_cnt + CNT_W'(accept);
  assign complete   = (cnt_next == CNT_W'(CHUNKS));
  assign out_free   = !rvalid || deque;
  assign flush_elig = (flush || flush_pend) && (cnt_next != '0);
  assign xfer       = (complete || flush_elig) && out_free;
  assign empty      = !rvalid && (fill_cnt == '0) && !flush_pend;

  // Slot i holds chunk i; its position in the word depends on chunk order
  for (genvar i = 0; i < CHUNKS; i++) begin : g_slot
    localparam int POS = LSB_FIRST ? i : (CHUNKS - 1 - i);
    logic [ENQ_WIDTH-1:0] q;
    que_fiao_slot #(.W(ENQ_WIDTH)) u_slot (
      .clk    (clk),
      .rst    (rst),
      .clr    (xfer),
      .we     (accept && (fill_cnt == CNT_W'(i))),
      .din    (wdata),
      .q      (q),
      .d_next (word_next[POS])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fill_cnt   <= '0;
      flush_pend <= 1'b0;
      rdata      <= '0;
      rcount     <= '0;
      rvalid     <= 1'b0;
    end else begin
      if (xfer) begin
        fill_cnt   <= '0;
        flush_pend <= 1'b0;
        rdata      <= word_next;
        rcount     <= cnt_next;
        rvalid     <= 1'b1;
      end else begin
        fill_cnt <= cnt_next;
        // Flush that cannot transfer yet is remembered and blocks enqueues
        if (flush && (cnt_next != '0)) flush_pend <= 1'b1;
        if (deque && rvalid) begin
          rdata  <= '0;
          rcount <= '0;
          rvalid <= 1'b0;
        end
      end
    end
  end
endmodule
